std_div_pipe_7: RTL and testbench
=================================

Name: std_div_pipe_7

Overview:
- Multi-cycle unsigned restoring divider with a go/done handshake, sized for 7-bit datapaths.
- Sits directly upstream of the 7-bit result registers: `out_quotient` / `out_remainder` feed their `in` ports, `done` drives their `write_en`.
- One quotient bit is produced per cycle; the result is valid for one `done` pulse and held afterwards.

Parameters:
- WIDTH, 7, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. reset=0 asserts; deassertion is synchronous to clk.
- go  input  1  start request; sampled only in IDLE.
- left  input  WIDTH  dividend (unsigned); sampled only on the start edge.
- right  input  WIDTH  divisor (unsigned); sampled only on the start edge.
- out_quotient  output  WIDTH  registered quotient.
- out_remainder  output  WIDTH  registered remainder.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, takes effect immediately, no clock needed):
  - state=IDLE.
  - out_quotient=0, out_remainder=0, done=0.
  - Internal dividend, divisor, partial remainder and counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - done=0.
  - On an edge with go=1: latch left→dividend and right→divisor, clear the partial remainder (WIDTH+1 bits) and the quotient shift register, set counter=0, go to RUN.
  - go=0: stay in IDLE.
- RUN, one iteration per edge:
  - t = {rem[WIDTH-1:0], dividend[WIDTH-1]}.
  - dividend shifts left by 1.
  - If t >= {1'b0, divisor}: rem = t - divisor and quotient bit = 1. Otherwise rem = t and quotient bit = 0.
  - The quotient bit shifts into the LSB of the quotient register.
  - counter increments.
  - On the iteration with counter==WIDTH-1:
    - out_quotient <= final quotient.
    - out_remainder <= rem[WIDTH-1:0].
    - done <= 1.
    - Go to DONE.
- DONE: lasts exactly one cycle with done=1, then IDLE and done <= 0.
- Latency:
  - go high in cycle 0 (start edge at the end of cycle 0) → done=1 in cycle WIDTH+1 (cycle 8 for WIDTH=7).
  - Outputs change on the same edge that raises done.
- Outputs hold their last result until the next completion or reset. They do not change during RUN.
- go is ignored in RUN and DONE.
  - Dropping go mid-RUN does not abort the operation.
  - left/right changing mid-RUN has no effect.
- go held high continuously: after DONE returns to IDLE, the next edge starts a new operation. done pulses every WIDTH+2 cycles (cycles 8, 17, 26, ...).
- Divide by zero (right=0):
  - Handled by the normal datapath with the same latency; no special state.
  - Result: out_quotient = all ones (127), out_remainder = left.
- Arithmetic is purely unsigned; no overflow is possible. Internal remainder compare/subtract is WIDTH+1 bits wide.
- Reset mid-operation:
  - Immediate return to IDLE; outputs and done go to 0 asynchronously.
  - After release a fresh go is required; no partial result is ever presented.
- done is never high for more than one consecutive cycle.

Test Plan:
- Reset, then left=100, right=7, go high for one cycle (cycle 0) → done=1 only in cycle 8; out_quotient=14, out_remainder=2; values hold after done falls.
- Boundary operands:
  - left=127, right=1 → q=127, r=0.
  - left=5, right=9 → q=0, r=5.
  - left=0, right=3 → q=0, r=0.
- Divide by zero: left=45, right=0 → done in cycle 8, q=127, r=45.
- Back-to-back with go held high from cycle 0:
  - Change left/right to 90/10 during cycle 3 → first result reflects the original operands (done in cycle 8).
  - Second result q=9, r=0 with done in cycle 17.
- Mid-run abuse and reset, starting 100/7 at cycle 0:
  - Drop go and toggle left/right in cycles 1–5 → result still 14/2 at cycle 8.
  - Repeat the start, then assert reset=0 during cycle 4 → outputs 0 and done 0 immediately; no done pulse after release until a new go.
- Random sweep, ≥2000 operand pairs including right=0 → compare q and r against a reference model (left/right and left%right; right=0 gives q=127, r=left); done exactly once per go, always at WIDTH+1 cycles.

Source files
------------

// File: rtl/std_div_pipe_7_if.sv
// Handshake and result bundle for the multi-cycle unsigned divider.
// The master drives go/operands; the slave (divider) returns the result and done pulse.
interface std_div_pipe_7_if #(
    parameter int WIDTH = 7
);
    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             done;

    modport master (
        output go,
        output left,
        output right,
        input  out_quotient,
        input  out_remainder,
        input  done
    );

    modport slave (
        input  go,
        input  left,
        input  right,
        output out_quotient,
        output out_remainder,
        output done
    );
endinterface

// File: rtl/std_div_pipe_7.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, go/done handshake,
// registered results held until the next completion or reset.
module std_div_pipe_7 #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    std_div_pipe_7_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q,       state_d;
    logic [WIDTH-1:0] dividend_q,    dividend_d;
    logic [WIDTH-1:0] divisor_q,     divisor_d;
    logic [WIDTH:0]   rem_q,         rem_d;
    logic [WIDTH-1:0] quot_q,        quot_d;
    logic [CW-1:0]    cnt_q,         cnt_d;
    logic [WIDTH-1:0] out_quot_q,    out_quot_d;
    logic [WIDTH-1:0] out_rem_q,     out_rem_d;
    logic             done_q,        done_d;

    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quot_next_s;

    // One restoring step: the invariant rem < divisor keeps the result within WIDTH bits.
    always_comb begin
        trial_s     = {rem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
        diff_s      = trial_s - {1'b0, divisor_q};
        ge_s        = (trial_s >= {1'b0, divisor_q});
        rem_next_s  = ge_s ? diff_s : trial_s;
        quot_next_s = (quot_q << 1) | {{(WIDTH-1){1'b0}}, ge_s};
    end

    // Next-state and register-update decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        out_quot_d = out_quot_q;
        out_rem_d  = out_rem_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    dividend_d = bus.left;
                    divisor_d  = bus.right;
                    rem_d      = {(WIDTH+1){1'b0}};
                    quot_d     = {WIDTH{1'b0}};
                    cnt_d      = {CW{1'b0}};
                    state_d    = ST_RUN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_RUN: begin
                dividend_d = dividend_q << 1;
                rem_d      = rem_next_s;
                quot_d     = quot_next_s;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    out_quot_d = quot_next_s;
                    out_rem_d  = rem_next_s[WIDTH-1:0];
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d    = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            dividend_q <= {WIDTH{1'b0}};
            divisor_q  <= {WIDTH{1'b0}};
            rem_q      <= {(WIDTH+1){1'b0}};
            quot_q     <= {WIDTH{1'b0}};
            cnt_q      <= {CW{1'b0}};
            out_quot_q <= {WIDTH{1'b0}};
            out_rem_q  <= {WIDTH{1'b0}};
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
            out_quot_q <= out_quot_d;
            out_rem_q  <= out_rem_d;
            done_q     <= done_d;
        end
    end

    assign bus.out_quotient  = out_quot_q;
    assign bus.out_remainder = out_rem_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_std_div_pipe_7.sv
// Directed and swept checks of std_div_pipe_7: latency, results, handshake corner cases.
module tb_std_div_pipe_7;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    std_div_pipe_7_if #(.WIDTH(7)) bus ();

    std_div_pipe_7 #(.WIDTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Start one operation (go high for cycle 0) and watch cycles 1..12 for done.
    task automatic do_op(input logic [6:0] l, input logic [6:0] r,
                         output int done_cyc, output int done_cnt,
                         output logic [6:0] q, output logic [6:0] rm);
        @(negedge clk);
        bus.go = 1'b1; bus.left = l; bus.right = r;
        @(posedge clk);
        #1 bus.go = 1'b0;
        done_cyc = -1; done_cnt = 0; q = 7'd0; rm = 7'd0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = i; q = bus.out_quotient; rm = bus.out_remainder;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.go = 1'b0; bus.left = 7'd0; bus.right = 7'd0;
        #1;
        checks++; if (bus.out_quotient !== 7'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", bus.out_quotient); end
        checks++; if (bus.out_remainder !== 7'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", bus.out_remainder); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int c, n; logic [6:0] q, rm;
        do_op(7'd100, 7'd7, c, n, q, rm);
        checks++; if (c !== 8) begin errors++; $display("FAIL basic_latency: got %0d want 8", c); end
        checks++; if (n !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n); end
        checks++; if (q !== 7'd14) begin errors++; $display("FAIL basic_q: got %0d want 14", q); end
        checks++; if (rm !== 7'd2) begin errors++; $display("FAIL basic_r: got %0d want 2", rm); end
        checks++; if (bus.out_quotient !== 7'd14 || bus.out_remainder !== 7'd2)
            begin errors++; $display("FAIL basic_hold: got %0d/%0d want 14/2", bus.out_quotient, bus.out_remainder); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_low: got %b want 0", bus.done); end
    endtask

    task automatic test_boundary();
        logic [6:0] tl [4] = '{7'd127, 7'd5, 7'd0, 7'd45};
        logic [6:0] tr [4] = '{7'd1,   7'd9, 7'd3, 7'd0};
        logic [6:0] eq [4] = '{7'd127, 7'd0, 7'd0, 7'd127};
        logic [6:0] er [4] = '{7'd0,   7'd5, 7'd0, 7'd45};
        int c, n; logic [6:0] q, rm;
        for (int k = 0; k < 4; k++) begin
            do_op(tl[k], tr[k], c, n, q, rm);
            checks++; if (c !== 8 || n !== 1) begin errors++; $display("FAIL bound%0d_timing: got cyc %0d cnt %0d want 8/1", k, c, n); end
            checks++; if (q !== eq[k]) begin errors++; $display("FAIL bound%0d_q: got %0d want %0d", k, q, eq[k]); end
            checks++; if (rm !== er[k]) begin errors++; $display("FAIL bound%0d_r: got %0d want %0d", k, rm, er[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2, n; logic [6:0] q1, r1, q2, r2;
        d1 = -1; d2 = -1; n = 0; q1 = 7'd0; r1 = 7'd0; q2 = 7'd0; r2 = 7'd0;
        @(negedge clk);
        bus.go = 1'b1; bus.left = 7'd100; bus.right = 7'd7;
        @(posedge clk);
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (i == 3) begin bus.left = 7'd90; bus.right = 7'd10; end
            if (bus.done === 1'b1) begin
                n++;
                if (d1 < 0) begin d1 = i; q1 = bus.out_quotient; r1 = bus.out_remainder; end
                else begin d2 = i; q2 = bus.out_quotient; r2 = bus.out_remainder; end
            end
            if (i == 18) bus.go = 1'b0;
        end
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", n); end
        checks++; if (d1 !== 8 || q1 !== 7'd14 || r1 !== 7'd2)
            begin errors++; $display("FAIL b2b_first: got cyc %0d %0d/%0d want 8 14/2", d1, q1, r1); end
        checks++; if (d2 !== 17 || q2 !== 7'd9 || r2 !== 7'd0)
            begin errors++; $display("FAIL b2b_second: got cyc %0d %0d/%0d want 17 9/0", d2, q2, r2); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_mid_run_abuse();
        int c, n; logic [6:0] q, rm;
        c = -1; n = 0; q = 7'd0; rm = 7'd0;
        @(negedge clk);
        bus.go = 1'b1; bus.left = 7'd100; bus.right = 7'd7;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i <= 5) begin
                bus.go = (i % 2 == 1) ? 1'b1 : 1'b0;
                bus.left = 7'($urandom_range(0, 127)); bus.right = 7'($urandom_range(0, 127));
            end else begin
                bus.go = 1'b0;
            end
            if (bus.done === 1'b1) begin
                n++;
                if (c < 0) begin c = i; q = bus.out_quotient; rm = bus.out_remainder; end
            end
        end
        checks++; if (c !== 8 || n !== 1) begin errors++; $display("FAIL abuse_timing: got cyc %0d cnt %0d want 8/1", c, n); end
        checks++; if (q !== 7'd14 || rm !== 7'd2) begin errors++; $display("FAIL abuse_result: got %0d/%0d want 14/2", q, rm); end
    endtask

    task automatic test_reset_mid();
        int n, c, k; logic [6:0] q, rm;
        n = 0;
        @(negedge clk);
        bus.go = 1'b1; bus.left = 7'd100; bus.right = 7'd7;
        @(posedge clk);
        #1 bus.go = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus.out_quotient !== 7'd0 || bus.out_remainder !== 7'd0)
            begin errors++; $display("FAIL rstmid_outputs: got %0d/%0d want 0/0", bus.out_quotient, bus.out_remainder); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n); end
        do_op(7'd100, 7'd7, c, k, q, rm);
        checks++; if (c !== 8 || q !== 7'd14 || rm !== 7'd2)
            begin errors++; $display("FAIL rstmid_restart: got cyc %0d %0d/%0d want 8 14/2", c, q, rm); end
    endtask

    task automatic test_random_sweep();
        int c, n; logic [6:0] l, r, q, rm, eq, er;
        for (int k = 0; k < 2000; k++) begin
            l = 7'($urandom_range(0, 127));
            r = (k % 16 == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            eq = (r == 7'd0) ? 7'd127 : l / r;
            er = (r == 7'd0) ? l : l % r;
            do_op(l, r, c, n, q, rm);
            checks++; if (c !== 8 || n !== 1) begin errors++; $display("FAIL rand_timing %0d/%0d: got cyc %0d cnt %0d want 8/1", l, r, c, n); end
            checks++; if (q !== eq) begin errors++; $display("FAIL rand_q %0d/%0d: got %0d want %0d", l, r, q, eq); end
            checks++; if (rm !== er) begin errors++; $display("FAIL rand_r %0d/%0d: got %0d want %0d", l, r, rm, er); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_mid_run_abuse();
        test_reset_mid();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
